// File: rtl/multicycle_muldiv_unit.sv
// multicycle_muldiv_unit: iterative RV32M multiply/divide with shift-add and restoring division
module multicycle_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      rd_in,
    output logic            ready,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nx;
    logic [2:0] op;
    logic [XLEN-1:0] a_abs, b_abs, rem, special_val, quo_fix, rem_fix, fix_val;
    logic [2*XLEN-1:0] acc, addend, prod_fix;
    logic [XLEN:0] rem_sh, diff;
    logic [CNT_W-1:0] cnt;
    logic neg_q, neg_r, a_sgn, b_sgn, div_zero, div_ovf, special, accept;
    assign a_sgn = operand_a[XLEN-1] & (func3 == 3'b001 || func3 == 3'b010 || (func3[2] && !func3[0]));
    assign b_sgn = operand_b[XLEN-1] & (func3 == 3'b001 || (func3[2] && !func3[0]));
    assign div_zero = func3[2] && operand_b == '0;
    assign div_ovf = func3[2] && !func3[0] && operand_a == {1'b1, {(XLEN-1){1'b0}}} && operand_b == '1;
    assign special = div_zero | div_ovf;
    assign special_val = div_zero ? (func3[1] ? operand_a : '1) : (func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
    assign addend = b_abs[cnt[4:0]] ? ({{XLEN{1'b0}}, a_abs} << cnt) : '0;
    assign rem_sh = {rem, a_abs[XLEN-1]};
    assign diff = rem_sh - {1'b0, b_abs};
    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fix = neg_r ? -rem : rem;
    assign fix_val = op[2] ? (op[1] ? rem_fix : quo_fix) : (op == 3'b000 ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);
    // next state and handshake outputs; flush always returns to IDLE and masks the result pulse
    always_comb begin
        ready = state == IDLE || state == DONE;
        busy = state == CALC || state == FIX;
        result_valid = state == DONE && !flush;
        accept = ready && start && !flush;
        state_nx = flush ? IDLE :
                   ready ? (start ? (special ? DONE : CALC) : IDLE) :
                   state == CALC ? (cnt == CNT_W'(XLEN-1) ? FIX : CALC) : DONE;
    end
    // state register
    always_ff @(posedge CLK) begin
        if (!RESET) state <= IDLE;
        else state <= state_nx;
    end
    // operand capture, one radix-2 iteration per CALC cycle, sign fix-up in FIX
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            op <= '0;
            rd_out <= '0;
            result <= '0;
            cnt <= '0;
            acc <= '0;
            rem <= '0;
            a_abs <= '0;
            b_abs <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            op <= func3;
            rd_out <= rd_in;
            a_abs <= a_sgn ? -operand_a : operand_a;
            b_abs <= b_sgn ? -operand_b : operand_b;
            neg_q <= a_sgn ^ b_sgn;
            neg_r <= a_sgn;
            cnt <= '0;
            acc <= '0;
            rem <= '0;
            if (special) result <= special_val;
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            if (op[2]) begin
                rem <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                acc <= {acc[2*XLEN-2:0], ~diff[XLEN]};
                a_abs <= a_abs << 1;
            end else begin
                acc <= acc + addend;
            end
        end else if (state == FIX && !flush) begin
            result <= fix_val;
        end
    end
endmodule
